keccak_round_scheduler: RTL and testbench
=========================================

// Module: keccak_round_scheduler
// PURPOSE
//  Top-level sequencer for the Keccak-f state-processing step units (colParity, rotate, permute, revaluate, addRC).
//  Per round: launches each enabled step unit in fixed order via its start/ready handshake.
//  Hands the shared state-memory port to the active step and publishes the round index (used by addRC).
//  Sits above the per-step control units; owns no datapath except its step/round counters.
// PARAMETERS
//  NUM_STEPS   5    number of step units sequenced per round (index 0 = colParity)
//  NUM_ROUNDS  24   rounds per permutation
//  SW          3    step-index width, >= clog2(NUM_STEPS)
//  RW          5    round-index width, >= clog2(NUM_ROUNDS)
// PORTS
//  clk         in   1          rising-edge clock
//  rst         in   1          async, active-high reset
//  start       in   1          begin a permutation; sampled only in IDLE
//  step_en     in   NUM_STEPS  per-step enable mask, sampled at permutation start; 0 = skip that step every round
//  step_ready  in   NUM_STEPS  ready of each step unit: 1 when idle, falls the cycle after its start
//  step_start  out  NUM_STEPS  one-hot, single-cycle start pulse to a step unit
//  mem_owner   out  SW         index of step unit granted the shared memory port
//  round_idx   out  RW         current round, 0..NUM_ROUNDS-1
//  ready       out  1          1 only in IDLE
//  done        out  1          single-cycle pulse when the last round completes
// BEHAVIOUR
//  Reset: state=IDLE, step_start=0, mem_owner=0, round_idx=0, ready=1, done=0. Reset mid-operation aborts immediately,
//   with no further start pulses; step units are reset by the same rst.
//  Outputs are Moore, decoded from state/counters; step counter s (SW bits) and round counter r (RW bits) are registered.
//  States and transitions:
//   IDLE      ready=1; start -> SYNC, latch step_en into en_q, s=0, r=0.
//   SYNC      wait until &step_ready==1 (all units idle) -> SEL.
//   SEL       en_q[s]==1 -> LAUNCH; else -> ADV (skip, no pulse).
//   LAUNCH    step_start[s]=1 for exactly this cycle -> WAIT_BUSY.
//   WAIT_BUSY step_ready[s]==0 -> WAIT_DONE; else stay.
//   WAIT_DONE step_ready[s]==1 -> ADV; else stay.
//   ADV       s==NUM_STEPS-1: s=0, and r==NUM_ROUNDS-1 -> DONE else r=r+1 -> SEL; otherwise s=s+1 -> SEL.
//   DONE      done=1 for one cycle -> IDLE; r cleared to 0 on entry to IDLE.
//  mem_owner = s in every state except IDLE/DONE (0); it holds stable from SEL through WAIT_DONE of that step.
//  The handshake never times out; a unit that never drops or raises ready stalls the scheduler (rst recovers).
//  start outside IDLE is ignored; step_en changes during a run are ignored (en_q only).
//  en_q all-zero: each step costs 2 cycles (SEL,ADV); the run completes in 2 + 2*NUM_STEPS*NUM_ROUNDS + 1 cycles after start.
//  Minimum per-step cost with a unit whose ready is low for k cycles: SEL+LAUNCH+1+k+ADV = k+4 cycles.
//  round_idx increments only in ADV of the last step; it never wraps inside a run.
// STRUCTURE
//  Shared package keccak_pkg: state encoding (localparams), NUM_STEPS/NUM_ROUNDS defaults, step index constants
//   STEP_COLPARITY=0 .. STEP_ADDRC=4.
//  One natural sub-module: keccak_step_round_counter (s/r counters with init/inc/carry-out, same style as the
//   per-step controllers' counters); the FSM remains in this module.
// TESTING
//  Reset then start=1, step_en=5'b11111, stub units that hold ready low 3 cycles -> step_start pulses in order 0..4,
//   round_idx 0..23, done after 24*5*7+2 cycles.
//  Enable mask 5'b00101 -> only step_start[0] and [2] ever pulse, 48 pulses total; mem_owner=2 while unit 2 is busy.
//  step_en=0 -> no step_start pulses; done asserts exactly 242 cycles after start sampled; ready returns next cycle.
//  step_ready[3] held 0 at start -> scheduler stays in SYNC, no pulse until it rises; start re-pulsed mid-run is ignored.
//  rst asserted while WAIT_DONE of step 1, round 7 -> next cycle ready=1, round_idx=0, step_start=0, done never pulses.
//  Unit 4 never drops ready -> scheduler stays in WAIT_BUSY with mem_owner=4 indefinitely; no second pulse is issued.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak-f round scheduler.
// Contents:
//   - default sizing: number of steps, number of rounds, step/round index widths
//   - step index constants (colParity .. addRC)
//   - scheduler state encoding
package keccak_pkg;

  localparam int KECCAK_NUM_STEPS  = 5;
  localparam int KECCAK_NUM_ROUNDS = 24;
  localparam int KECCAK_SW         = 3;
  localparam int KECCAK_RW         = 5;

  localparam int STEP_COLPARITY = 0;
  localparam int STEP_ROTATE    = 1;
  localparam int STEP_PERMUTE   = 2;
  localparam int STEP_REVALUATE = 3;
  localparam int STEP_ADDRC     = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SYNC      = 3'd1,
    ST_SEL       = 3'd2,
    ST_LAUNCH    = 3'd3,
    ST_WAIT_BUSY = 3'd4,
    ST_WAIT_DONE = 3'd5,
    ST_ADV       = 3'd6,
    ST_DONE      = 3'd7
  } sched_state_e;

endpackage

// File: rtl/keccak_step_round_counter.sv
// Step/round counter pair for the round scheduler.
// Ports:
//   i_clk, i_rst    clock, async active-high reset
//   i_init          clear both counters
//   i_inc           advance one step; wraps step into the round counter
//   o_step          current step index
//   o_step_next     step index after this cycle's update
//   o_round_next    round index after this cycle's update
//   o_step_last     current step is the last of the round
//   o_round_last    current round is the last of the permutation
module keccak_step_round_counter
  import keccak_pkg::*;
#(
  parameter int NUM_STEPS  = KECCAK_NUM_STEPS,
  parameter int NUM_ROUNDS = KECCAK_NUM_ROUNDS,
  parameter int SW         = KECCAK_SW,
  parameter int RW         = KECCAK_RW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_init,
  input  logic          i_inc,
  output logic [SW-1:0] o_step,
  output logic [SW-1:0] o_step_next,
  output logic [RW-1:0] o_round_next,
  output logic          o_step_last,
  output logic          o_round_last
);

  logic [SW-1:0] r_step;
  logic [RW-1:0] r_round;
  logic [SW-1:0] w_step_next;
  logic [RW-1:0] w_round_next;

  assign o_step_last  = (r_step == SW'(NUM_STEPS - 1));
  assign o_round_last = (r_round == RW'(NUM_ROUNDS - 1));

  // Next counter values: init has priority; the round counter saturates on
  // the last round so it never wraps inside a run (init clears it afterwards).
  always_comb begin
    w_step_next  = r_step;
    w_round_next = r_round;
    if (i_init) begin
      w_step_next  = {SW{1'b0}};
      w_round_next = {RW{1'b0}};
    end else if (i_inc) begin
      if (o_step_last) begin
        w_step_next = {SW{1'b0}};
        if (o_round_last) begin
          w_round_next = r_round;
        end else begin
          w_round_next = r_round + RW'(1);
        end
      end else begin
        w_step_next  = r_step + SW'(1);
        w_round_next = r_round;
      end
    end else begin
      w_step_next  = r_step;
      w_round_next = r_round;
    end
  end

  // Counter registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_step  <= {SW{1'b0}};
      r_round <= {RW{1'b0}};
    end else begin
      r_step  <= w_step_next;
      r_round <= w_round_next;
    end
  end

  assign o_step       = r_step;
  assign o_step_next  = w_step_next;
  assign o_round_next = w_round_next;

endmodule

// File: rtl/keccak_round_scheduler.sv
// Top-level sequencer for the Keccak-f step units. Each round it launches
// every enabled step unit in index order through a start/ready handshake,
// grants the shared state-memory port to the active step and publishes the
// round index.
// Ports:
//   i_clk          rising-edge clock
//   i_rst          async active-high reset (aborts any run)
//   i_start        begin a permutation (only honoured while idle)
//   i_step_en      per-step enable mask, captured at start
//   i_step_ready   per-unit ready (high when the unit is idle)
//   o_step_start   one-hot single-cycle start pulse
//   o_mem_owner    index of the unit owning the memory port
//   o_round_idx    current round
//   o_ready        high only while idle
//   o_done         single-cycle pulse at the end of the last round
module keccak_round_scheduler
  import keccak_pkg::*;
#(
  parameter int NUM_STEPS  = KECCAK_NUM_STEPS,
  parameter int NUM_ROUNDS = KECCAK_NUM_ROUNDS,
  parameter int SW         = KECCAK_SW,
  parameter int RW         = KECCAK_RW
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [NUM_STEPS-1:0] i_step_en,
  input  logic [NUM_STEPS-1:0] i_step_ready,
  output logic [NUM_STEPS-1:0] o_step_start,
  output logic [SW-1:0]        o_mem_owner,
  output logic [RW-1:0]        o_round_idx,
  output logic                 o_ready,
  output logic                 o_done
);

  localparam logic [NUM_STEPS-1:0] LP_ONE = {{(NUM_STEPS-1){1'b0}}, 1'b1};

  sched_state_e         r_state;
  sched_state_e         w_state_next;
  logic [NUM_STEPS-1:0] r_en_q;
  logic                 w_cnt_init;
  logic                 w_cnt_inc;
  logic [SW-1:0]        w_step;
  logic [SW-1:0]        w_step_next;
  logic [RW-1:0]        w_round_next;
  logic                 w_step_last;
  logic                 w_round_last;
  logic                 w_unit_ready;
  logic                 w_unit_en;
  logic                 w_all_ready;
  logic [NUM_STEPS-1:0] w_start_vec;
  logic [SW-1:0]        w_owner_next;

  logic [NUM_STEPS-1:0] r_step_start;
  logic [SW-1:0]        r_mem_owner;
  logic [RW-1:0]        r_round_idx;
  logic                 r_ready;
  logic                 r_done;

  keccak_step_round_counter #(
    .NUM_STEPS  (NUM_STEPS),
    .NUM_ROUNDS (NUM_ROUNDS),
    .SW         (SW),
    .RW         (RW)
  ) u_cnt (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_init       (w_cnt_init),
    .i_inc        (w_cnt_inc),
    .o_step       (w_step),
    .o_step_next  (w_step_next),
    .o_round_next (w_round_next),
    .o_step_last  (w_step_last),
    .o_round_last (w_round_last)
  );

  assign w_unit_ready = i_step_ready[w_step];
  assign w_unit_en    = r_en_q[w_step];
  assign w_all_ready  = &i_step_ready;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Enable mask is frozen for the whole run
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_en_q <= {NUM_STEPS{1'b0}};
    end else if ((r_state == ST_IDLE) && i_start) begin
      r_en_q <= i_step_en;
    end else begin
      r_en_q <= r_en_q;
    end
  end

  // Next-state and counter control
  always_comb begin
    w_state_next = r_state;
    w_cnt_init   = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_next = ST_SYNC;
          w_cnt_init   = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SYNC: begin
        if (w_all_ready) begin
          w_state_next = ST_SEL;
        end else begin
          w_state_next = ST_SYNC;
        end
      end
      ST_SEL: begin
        if (w_unit_en) begin
          w_state_next = ST_LAUNCH;
        end else begin
          w_state_next = ST_ADV;
        end
      end
      ST_LAUNCH: begin
        w_state_next = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!w_unit_ready) begin
          w_state_next = ST_WAIT_DONE;
        end else begin
          w_state_next = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_DONE: begin
        if (w_unit_ready) begin
          w_state_next = ST_ADV;
        end else begin
          w_state_next = ST_WAIT_DONE;
        end
      end
      ST_ADV: begin
        w_cnt_inc = 1'b1;
        if (w_step_last && w_round_last) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_SEL;
        end
      end
      ST_DONE: begin
        // Clearing here means the round index reads 0 on entry to IDLE.
        w_cnt_init   = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_cnt_init   = 1'b1;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Output decode of the upcoming state, so the registered outputs line up
  // with the state they describe.
  always_comb begin
    w_start_vec  = {NUM_STEPS{1'b0}};
    w_owner_next = {SW{1'b0}};
    if (w_state_next == ST_LAUNCH) begin
      w_start_vec = LP_ONE << w_step_next;
    end else begin
      w_start_vec = {NUM_STEPS{1'b0}};
    end
    if ((w_state_next == ST_IDLE) || (w_state_next == ST_DONE)) begin
      w_owner_next = {SW{1'b0}};
    end else begin
      w_owner_next = w_step_next;
    end
  end

  // Output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_step_start <= {NUM_STEPS{1'b0}};
      r_mem_owner  <= SW'(STEP_COLPARITY);
      r_round_idx  <= {RW{1'b0}};
      r_ready      <= 1'b1;
      r_done       <= 1'b0;
    end else begin
      r_step_start <= w_start_vec;
      r_mem_owner  <= w_owner_next;
      r_round_idx  <= w_round_next;
      r_ready      <= (w_state_next == ST_IDLE);
      r_done       <= (w_state_next == ST_DONE);
    end
  end

  assign o_step_start = r_step_start;
  assign o_mem_owner  = r_mem_owner;
  assign o_round_idx  = r_round_idx;
  assign o_ready      = r_ready;
  assign o_done       = r_done;

endmodule

// File: tb/tb_keccak_round_scheduler.sv
// Self-checking bench for keccak_round_scheduler: stub step units with a
// configurable busy time, an expected-pulse queue built from the enable mask,
// and a per-cycle compare process.
module tb_keccak_round_scheduler;

  localparam int NS = 5;
  localparam int NR = 24;
  localparam int SW = 3;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NS-1:0] step_en;
  logic [NS-1:0] step_ready;
  logic [NS-1:0] step_start;
  logic [SW-1:0] mem_owner;
  logic [RW-1:0] round_idx;
  logic          ready;
  logic          done;

  keccak_round_scheduler dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_step_en    (step_en),
    .i_step_ready (step_ready),
    .o_step_start (step_start),
    .o_mem_owner  (mem_owner),
    .o_round_idx  (round_idx),
    .o_ready      (ready),
    .o_done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub step units: ready drops the cycle after a start pulse, for unit_lat cycles.
  int unsigned   busy_cnt [NS];
  logic [NS-1:0] hold_low;
  logic [NS-1:0] no_drop;
  int unsigned   unit_lat;

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < NS; i++) begin
      if (rst) busy_cnt[i] <= 0;
      else if (step_start[i] && !no_drop[i]) busy_cnt[i] <= unit_lat;
      else if (busy_cnt[i] != 0) busy_cnt[i] <= busy_cnt[i] - 1;
    end
  end

  always_comb begin
    step_ready = '0;
    for (int i = 0; i < NS; i++) step_ready[i] = (busy_cnt[i] == 0) && !hold_low[i];
  end

  // Model and scoreboard
  typedef struct { int step; int round; } pulse_t;
  pulse_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int t_start = 0;
  int exp_lat = 0;
  int pulses_seen = 0;
  int done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every enabled step once per round, rounds in order.
  function automatic void build_expect(input logic [NS-1:0] en);
    pulse_t p;
    exp_q.delete();
    for (int r = 0; r < NR; r++)
      for (int s = 0; s < NS; s++)
        if (en[s]) begin
          p.step = s; p.round = r;
          exp_q.push_back(p);
        end
  endfunction

  // Cycles from the start cycle to the done cycle: IDLE+SYNC, then k+4 per
  // enabled step and 2 per skipped step.
  function automatic int model_latency(input logic [NS-1:0] en, input int k);
    int total = 2;
    for (int r = 0; r < NR; r++)
      for (int s = 0; s < NS; s++)
        total += en[s] ? (k + 4) : 2;
    return total;
  endfunction

  // Per-cycle compare process
  initial begin
    logic prev_done;
    pulse_t e;
    int idx;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (step_start != '0) begin
          pulses_seen++;
          idx = -1;
          for (int i = 0; i < NS; i++) if (step_start[i]) idx = i;
          check("start_onehot", 32'($onehot(step_start)), 1);
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", 32'(step_start), 0);
          end else begin
            e = exp_q.pop_front();
            check("pulse_step", idx, e.step);
            check("pulse_round", 32'(round_idx), e.round);
            check("pulse_owner", 32'(mem_owner), e.step);
          end
        end
        for (int i = 0; i < NS; i++)
          if (busy_cnt[i] != 0) check("owner_while_busy", 32'(mem_owner), i);
        if (done) begin
          done_seen++;
          check("done_single_cycle", 32'(prev_done), 0);
          check("done_latency", cyc - t_start, exp_lat);
          check("pending_pulses", exp_q.size(), 0);
        end
        prev_done = done;
      end else begin
        prev_done = 1'b0;
      end
    end
  end

  // One complete run; hold3>0 keeps unit 3 not-ready for hold3 SYNC cycles.
  task automatic do_run(input logic [NS-1:0] en, input int k, input int hold3,
                        input bit repulse, output int lat, output int npulses);
    int p0;
    bit got;
    unit_lat = k;
    build_expect(en);
    exp_lat = model_latency(en, k) + ((hold3 > 1) ? hold3 - 1 : 0);
    p0 = pulses_seen;
    got = 1'b0;
    lat = -1;
    if (hold3 > 0) hold_low[3] = 1'b1;
    step_en = en;
    start = 1'b1;
    t_start = cyc;
    @(negedge clk);
    start = 1'b0;
    step_en = ~en;
    if (hold3 > 0) begin
      repeat (hold3 - 1) @(negedge clk);
      check("sync_no_pulse", pulses_seen - p0, 0);
      check("sync_ready_low", 32'(ready), 0);
      hold_low[3] = 1'b0;
    end
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      start = (repulse && c == 40) ? 1'b1 : 1'b0;
      if (done) begin
        got = 1'b1;
        lat = cyc - t_start;
        break;
      end
    end
    start = 1'b0;
    check("done_reached", 32'(got), 1);
    npulses = pulses_seen - p0;
    @(negedge clk);
    check("ready_after_done", 32'(ready), 1);
    check("round_after_done", 32'(round_idx), 0);
    check("done_dropped", 32'(done), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, np, p0, d0;
    bit found;
    rst = 1'b1; start = 1'b0; step_en = '0; hold_low = '0; no_drop = '0; unit_lat = 3;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(ready), 1);
    check("rst_step_start", 32'(step_start), 0);
    check("rst_mem_owner", 32'(mem_owner), 0);
    check("rst_round_idx", 32'(round_idx), 0);
    check("rst_done", 32'(done), 0);

    // All steps, units busy 3 cycles
    do_run(5'b11111, 3, 0, 1'b0, lat, np);
    check("all_latency_literal", lat, 842);
    check("all_pulse_count", np, 120);

    // Only steps 0 and 2
    do_run(5'b00101, 3, 0, 1'b0, lat, np);
    check("mask_latency_literal", lat, 482);
    check("mask_pulse_count", np, 48);

    // Nothing enabled
    do_run(5'b00000, 3, 0, 1'b0, lat, np);
    check("empty_latency_literal", lat, 242);
    check("empty_pulse_count", np, 0);

    // Unit 3 busy at start holds SYNC; start re-pulsed mid-run is ignored
    do_run(5'b01001, 2, 10, 1'b1, lat, np);
    check("sync_latency_literal", lat, 443);
    check("sync_pulse_count", np, 48);
    repeat (30) @(negedge clk);
    check("no_restart_ready", 32'(ready), 1);

    // Reset during WAIT_DONE of step 1, round 7
    unit_lat = 3;
    build_expect(5'b11111);
    exp_lat = model_latency(5'b11111, 3);
    step_en = 5'b11111; start = 1'b1; t_start = cyc;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (step_start[1] && round_idx == 5'd7) begin found = 1'b1; break; end
    end
    check("rst_target_found", 32'(found), 1);
    repeat (2) @(negedge clk);
    check("owner_before_rst", 32'(mem_owner), 1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("abort_ready", 32'(ready), 1);
    check("abort_round_idx", 32'(round_idx), 0);
    check("abort_step_start", 32'(step_start), 0);
    check("abort_done", 32'(done), 0);
    rst = 1'b0;
    p0 = pulses_seen; d0 = done_seen;
    repeat (60) @(negedge clk);
    @(negedge clk);
    check("abort_no_pulse", pulses_seen - p0, 0);
    check("abort_no_done", done_seen - d0, 0);

    // Unit 4 never drops ready: scheduler parks in WAIT_BUSY
    no_drop[4] = 1'b1;
    build_expect(5'b10000);
    exp_lat = model_latency(5'b10000, 3);
    p0 = pulses_seen; d0 = done_seen;
    step_en = 5'b10000; start = 1'b1; t_start = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    @(negedge clk);
    check("stall_one_pulse", pulses_seen - p0, 1);
    check("stall_owner", 32'(mem_owner), 4);
    check("stall_ready", 32'(ready), 0);
    check("stall_no_done", done_seen - d0, 0);
    rst = 1'b1;
    exp_q.delete();
    no_drop = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("recover_ready", 32'(ready), 1);
    check("recover_owner", 32'(mem_owner), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
